sumador_acumulador_sat: RTL

//  Parametrised signed saturating adder/accumulator, successor of the two-operand saturating adder.

---
 rtl/sumador_acumulador_sat_if.sv | 39 +++
 rtl/sumador_acumulador_sat.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sumador_acumulador_sat_if.sv
// -----------------------------------------------------------------------------
// sumador_acumulador_sat_if
// Operand/result bundle for the saturating adder/accumulator.
//   start_i    : 1-cycle pulse that opens an accumulate transaction
//   mode_i     : 0 = single add, 1 = accumulate
//   inValid_i  : a_i/b_i carry a valid pair this cycle
//   a_i, b_i   : signed W-bit operands
//   sout_o     : signed saturated result (registered)
//   outValid_o : 1-cycle pulse, sout_o is new
//   ovf_o      : positive saturation in the presented result
//   unf_o      : negative saturation in the presented result
//   busy_o     : accumulate transaction in progress
// The slave modport is the adder's view; the master modport is the
// producer/consumer around it.
// -----------------------------------------------------------------------------
interface sumador_acumulador_sat_if #(
    parameter int W = 25
);
    logic         start_i;
    logic         mode_i;
    logic         inValid_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [W-1:0] sout_o;
    logic         outValid_o;
    logic         ovf_o;
    logic         unf_o;
    logic         busy_o;

    modport slave (
        input  start_i, mode_i, inValid_i, a_i, b_i,
        output sout_o, outValid_o, ovf_o, unf_o, busy_o
    );

    modport master (
        output start_i, mode_i, inValid_i, a_i, b_i,
        input  sout_o, outValid_o, ovf_o, unf_o, busy_o
    );
endinterface

// File: rtl/sumador_acumulador_sat.sv
// -----------------------------------------------------------------------------
// sumador_acumulador_sat
// Signed saturating adder / accumulator placed after the multiplier stage of
// the filter datapath.
//   Mode 0: one registered saturated add per valid pair (latency 1).
//   Mode 1: N_TERMS pairs are each saturated, then summed into a saturating
//           accumulator; one result is emitted with sticky overflow flags.
// Ports
//   clk_i : clock, all state changes on the rising edge
//   rst_i : synchronous active-high reset, dominates every input
//   bus   : operand/result bundle (slave modport), see the interface file
// -----------------------------------------------------------------------------
module sumador_acumulador_sat #(
    parameter int W       = 25,
    parameter int N_TERMS = 8,
    parameter int CNT_W   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    sumador_acumulador_sat_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ACUM, DONE} state_t;

    // Clamp limits, both at result width and at the widened compute width.
    localparam logic        [W-1:0] MAX_W   = {1'b0, {(W-1){1'b1}}};
    localparam logic        [W-1:0] MIN_W   = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W+1:0] MAX_EXT = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MIN_EXT = {3'b111, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0]    LAST    = CNT_W'(N_TERMS - 1);

    state_t             state_q, state_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               stickyOvf_q, stickyOvf_d;
    logic               stickyUnf_q, stickyUnf_d;
    logic [W-1:0]       sout_q, sout_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               outValid_q, outValid_d;

    logic signed [W+1:0] pairSum;
    logic [W-1:0]        pairSat;
    logic                pairOvf, pairUnf;
    logic signed [W+1:0] accSum;
    logic [W-1:0]        accSat;
    logic                accOvf, accUnf;

    // Two saturation stages: the operand pair is clamped first, then the
    // clamped pair is added to the accumulator and clamped again. Sums are
    // formed two bits wider so no intermediate value can wrap.
    always_comb begin
        pairSum = {{2{bus.a_i[W-1]}}, bus.a_i} + {{2{bus.b_i[W-1]}}, bus.b_i};
        pairOvf = (pairSum > MAX_EXT);
        pairUnf = (pairSum < MIN_EXT);
        if (pairOvf)      pairSat = MAX_W;
        else if (pairUnf) pairSat = MIN_W;
        else              pairSat = pairSum[W-1:0];

        accSum = {{2{acc_q[W-1]}}, acc_q} + {{2{pairSat[W-1]}}, pairSat};
        accOvf = (accSum > MAX_EXT);
        accUnf = (accSum < MIN_EXT);
        if (accOvf)      accSat = MAX_W;
        else if (accUnf) accSat = MIN_W;
        else             accSat = accSum[W-1:0];
    end

    // State and datapath registers; reset returns everything to a clean IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            stickyOvf_q <= 1'b0;
            stickyUnf_q <= 1'b0;
            sout_q      <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            outValid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            stickyOvf_q <= stickyOvf_d;
            stickyUnf_q <= stickyUnf_d;
            sout_q      <= sout_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            outValid_q  <= outValid_d;
        end
    end

    // Next-state logic. Mode and Start only matter in IDLE; the valid pulse
    // defaults low so it lasts exactly one cycle, and the result registers
    // hold between results.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        stickyOvf_d = stickyOvf_q;
        stickyUnf_d = stickyUnf_q;
        sout_d      = sout_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        outValid_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!bus.mode_i) begin
                    if (bus.inValid_i) begin
                        sout_d     = pairSat;
                        ovf_d      = pairOvf;
                        unf_d      = pairUnf;
                        outValid_d = 1'b1;
                    end
                end else if (bus.start_i) begin
                    // A pair presented together with Start is dropped.
                    acc_d       = '0;
                    count_d     = '0;
                    stickyOvf_d = 1'b0;
                    stickyUnf_d = 1'b0;
                    state_d     = ACUM;
                end
            end
            ACUM: begin
                if (bus.inValid_i) begin
                    acc_d       = accSat;
                    count_d     = count_q + CNT_W'(1);
                    stickyOvf_d = stickyOvf_q | pairOvf | accOvf;
                    stickyUnf_d = stickyUnf_q | pairUnf | accUnf;
                    if (count_q == LAST) begin
                        // Final term: publish the result including this step's flags.
                        sout_d     = accSat;
                        ovf_d      = stickyOvf_q | pairOvf | accOvf;
                        unf_d      = stickyUnf_q | pairUnf | accUnf;
                        outValid_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come straight from registers; Busy covers ACUM and DONE.
    always_comb begin
        bus.sout_o     = sout_q;
        bus.outValid_o = outValid_q;
        bus.ovf_o      = ovf_q;
        bus.unf_o      = unf_q;
        bus.busy_o     = (state_q != IDLE);
    end

endmodule
